// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline boundary register with a valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall counter: define EX_MEM_STALL_CNT_EN to add the stall_cnt port.
module ex_mem_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter int                REG_AW    = 5,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_alu_src_b,
    input  logic [REG_AW-1:0] in_write_dst,
    input  logic [DATA_W-1:0] in_b_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_alu_src_b,
    output logic [REG_AW-1:0] out_write_dst,
    output logic [DATA_W-1:0] out_b_reg
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // state | meaning
    // EMPTY | main and skid invalid
    // ONE   | main valid (drives outputs), skid invalid
    // FULL  | main and skid valid, in_ready low
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] alu_src_b;
        logic [REG_AW-1:0] write_dst;
        logic [DATA_W-1:0] b_reg;
    } beat_t;

    state_t state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    beat_t  in_beat;
    logic   accept;
    logic   drain;

    assign in_beat   = '{instr: in_instr, alu_out: in_alu_out, alu_src_b: in_alu_src_b,
                         write_dst: in_write_dst, b_reg: in_b_reg};
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush wins over everything; a drain in this cycle has already been seen by MEM.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_beat;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_beat;
                    end else if (accept) begin
                        skid_d  = in_beat;
                        state_d = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
`ifdef EX_MEM_STALL_CNT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
`ifdef EX_MEM_STALL_CNT_EN
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
`endif
        end
    end

    // Bubbles must never look like a register write downstream.
    assign out_instr     = out_valid ? main_q.instr : NOP_INSTR;
    assign out_write_dst = out_valid ? main_q.write_dst : '0;
    assign out_alu_out   = main_q.alu_out;
    assign out_alu_src_b = main_q.alu_src_b;
    assign out_b_reg     = main_q.b_reg;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: queue-based reference model plus directed and random stimulus.
module tb_ex_mem_stage_reg;
    localparam int          DATA_W = 32;
    localparam int          REG_AW = 5;
    localparam logic [31:0] NOP    = 32'h00000000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr = '0;
    logic [DATA_W-1:0] in_alu_out = '0;
    logic [DATA_W-1:0] in_alu_src_b = '0;
    logic [REG_AW-1:0] in_write_dst = '0;
    logic [DATA_W-1:0] in_b_reg = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_alu_out;
    logic [DATA_W-1:0] out_alu_src_b;
    logic [REG_AW-1:0] out_write_dst;
    logic [DATA_W-1:0] out_b_reg;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    ex_mem_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_alu_out(in_alu_out), .in_alu_src_b(in_alu_src_b),
        .in_write_dst(in_write_dst), .in_b_reg(in_b_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_alu_out(out_alu_out), .out_alu_src_b(out_alu_src_b),
        .out_write_dst(out_write_dst), .out_b_reg(out_b_reg)
`ifdef EX_MEM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] alu_src_b;
        logic [REG_AW-1:0] write_dst;
        logic [DATA_W-1:0] b_reg;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] m_stall = '0;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: a FIFO of capacity two; beats leave from the front, enter at the back.
    always @(posedge clk or negedge rst) begin : model
        bit    mv, acc, drn;
        beat_t b;
        if (!rst) begin
            mq.delete();
            m_stall = '0;
        end else begin
            mv  = (mq.size() > 0);
            acc = in_valid && (mq.size() < 2);
            drn = mv && out_ready;
            if (mv && !out_ready) m_stall = m_stall + 32'd1;
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) begin
                    b.instr = in_instr; b.alu_out = in_alu_out; b.alu_src_b = in_alu_src_b;
                    b.write_dst = in_write_dst; b.b_reg = in_b_reg;
                    mq.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
            chk("out_alu_out", 64'(out_alu_out), 64'(mq[0].alu_out));
            chk("out_alu_src_b", 64'(out_alu_src_b), 64'(mq[0].alu_src_b));
            chk("out_write_dst", 64'(out_write_dst), 64'(mq[0].write_dst));
            chk("out_b_reg", 64'(out_b_reg), 64'(mq[0].b_reg));
        end else begin
            chk("bubble_instr", 64'(out_instr), 64'(NOP));
            chk("bubble_dst", 64'(out_write_dst), 64'd0);
        end
`ifdef EX_MEM_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] srcb, input logic [4:0] dst, input logic [31:0] breg);
        in_valid = v; in_instr = ins; in_alu_out = alu; in_alu_src_b = srcb;
        in_write_dst = dst; in_b_reg = breg;
    endtask

    initial begin
        // Reset then single beat
        rst = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        rst = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'h8C430004, 32'h10, 32'h4, 5'd3, 32'h55);
        step();
        offer(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_instr", 64'(out_instr), 64'h8C430004);
        chk("single_alu", 64'(out_alu_out), 64'h10);
        chk("single_dst", 64'(out_write_dst), 64'd3);
        step();
        chk("single_after", 64'(out_valid), 64'd0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'h1000 + 32'(i), 32'(i * 3), 32'(i * 5), 5'(i + 1), 32'(i * 7));
            step();
            chk("stream_instr", 64'(out_instr), 64'h1000 + 64'(i));
        end
        offer(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        step();

        // Backpressure: A, B fill; C held off
        out_ready = 1'b0;
        offer(1'b1, 32'hA, 32'h1, 32'h2, 5'd10, 32'h3); step();
        offer(1'b1, 32'hB, 32'h4, 32'h5, 5'd11, 32'h6); step();
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        offer(1'b1, 32'hC, 32'h7, 32'h8, 5'd12, 32'h9); step();
        chk("bp_hold_A", 64'(out_instr), 64'hA);
        out_ready = 1'b1;
        step();
        chk("bp_B", 64'(out_instr), 64'hB);
        step();
        chk("bp_C", 64'(out_instr), 64'hC);
        offer(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush in FULL with D offered
        out_ready = 1'b0;
        offer(1'b1, 32'hA1, 32'h1, 32'h2, 5'd20, 32'h3); step();
        offer(1'b1, 32'hB1, 32'h4, 32'h5, 5'd21, 32'h6); step();
        flush = 1'b1;
        offer(1'b1, 32'hD1, 32'h7, 32'h8, 5'd22, 32'h9);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_dst", 64'(out_write_dst), 64'd0);
        chk("flush_instr", 64'(out_instr), 64'(NOP));
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (2) step();
        chk("flush_no_D", 64'(out_valid), 64'd0);

        // Async reset mid-FULL
        out_ready = 1'b0;
        offer(1'b1, 32'hE1, 32'h1, 32'h1, 5'd5, 32'h1); step();
        offer(1'b1, 32'hE2, 32'h2, 32'h2, 5'd6, 32'h2); step();
        offer(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_instr", 64'(out_instr), 64'(NOP));
        step();
        rst = 1'b1;

`ifdef EX_MEM_STALL_CNT_EN
        offer(1'b1, 32'hF1, 32'h1, 32'h1, 5'd7, 32'h1); step();
        offer(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        repeat (5) step();
        chk("stall_5", 64'(stall_cnt), 64'd5);
        flush = 1'b1; out_ready = 1'b1; step();
        flush = 1'b0;
        chk("stall_after_flush", 64'(stall_cnt), 64'd5);
        #2 rst = 1'b0; #1;
        chk("stall_reset", 64'(stall_cnt), 64'd0);
        step();
        rst = 1'b1;
`endif

        // Random traffic with mixed backpressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            offer(1'b0, $urandom, $urandom, $urandom, 5'($urandom), $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX→MEM pipeline boundary register for the MIPS pipeline.
- Carries instruction, ALU result, ALU source-B, store data (B register) and write-destination fields.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure from MEM never drops or duplicates a beat.
- Supports synchronous flush (bubble insertion) for branch/exception squash.

Parameters:
- DATA_W, 32, width of the instr, alu_out, alu_src_b and b_reg fields.
- REG_AW, 5, width of the write-destination register address.
- NOP_INSTR, 32'h00000000, instruction value presented on out_instr whenever out_valid=0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous squash of all held beats
- in_valid  in  1  EX presents a beat
- in_ready  out  1  register can accept a beat
- in_instr  in  DATA_W  EX instruction
- in_alu_out  in  DATA_W  ALU result
- in_alu_src_b  in  DATA_W  ALU operand B
- in_write_dst  in  REG_AW  destination register
- in_b_reg  in  DATA_W  store data
- out_valid  out  1  beat held for MEM
- out_ready  in  1  MEM consumes the beat
- out_instr, out_alu_out, out_alu_src_b  out  DATA_W  registered fields
- out_write_dst  out  REG_AW  registered destination
- out_b_reg  out  DATA_W  registered store data
- stall_cnt  out  32  only present with the optional feature

Behaviour:
- Storage: main entry (drives outputs) plus skid entry; each entry has its own valid bit.
- in_ready = !skid_valid. It is combinational from a register only and never depends on out_ready.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States:
  - EMPTY (main and skid invalid)
  - ONE (main valid, skid invalid)
  - FULL (both valid)
- Transitions (with flush=0):
  - EMPTY: accept → ONE; the beat loads main and is visible on outputs the next cycle (1-cycle latency).
  - ONE, accept & drain → ONE, main reloaded with the new beat.
  - ONE, accept only → FULL, the new beat goes to skid.
  - ONE, drain only → EMPTY.
  - ONE, neither → hold.
  - FULL: in_ready=0, so no accept. Drain → ONE with skid moved into main. Otherwise hold.
- Ordering is strict FIFO; no beat is lost or duplicated under any out_ready pattern.
- Flush (synchronous, highest priority):
  - Next cycle: both valids=0 and state=EMPTY.
  - A beat offered in the flush cycle is discarded even if in_ready=1.
  - A drain in the flush cycle still completes; MEM sees the current beat that cycle.
- Bubble outputs: whenever out_valid=0, out_instr=NOP_INSTR and out_write_dst=0, so MEM/WB never writes a register. Other data fields hold don't-care values; the bench checks them only when out_valid=1.
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - Both valids=0 and all stored fields=0.
  - out_instr=NOP_INSTR, out_valid=0, in_ready=1.
  - Reset release is sampled synchronously: the first accept can occur on the first rising edge with rst=1.
- Widths: fields are copied unmodified. No arithmetic is performed on the payload.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- When defined:
  - stall_cnt port exists: a 32-bit counter incremented each cycle with out_valid=1 and out_ready=0.
  - Wraps 0xFFFFFFFF→0.
  - Cleared by reset; not cleared by flush.
- When undefined: the port and counter are absent, and the block's behaviour is otherwise identical.

Test Plan:
- Reset then single beat: rst low 3 cycles → out_valid=0, in_ready=1, out_instr=0. Release, present instr=0x8C430004, alu_out=0x10, write_dst=3, out_ready=1 → next cycle out_valid=1 with the same values, then out_valid=0.
- Streaming: 8 consecutive beats, out_ready=1 always → one beat out per cycle, in order, 1-cycle latency, in_ready stays 1.
- Backpressure: out_ready=0 while beats A, B offered → state FULL, in_ready=0, C held off. Raise out_ready → A, B, C delivered in order, no loss or duplication.
- Flush in FULL with beat D offered: next cycle out_valid=0, out_write_dst=0, out_instr=NOP_INSTR. D never appears; in_ready=1.
- Async reset mid-FULL: drop rst between clock edges → outputs clear immediately without a clock edge.
- With EX_MEM_STALL_CNT_EN: hold out_ready=0 for 5 cycles with out_valid=1 → stall_cnt=5. Flush → stall_cnt still 5. Reset → 0.
